router_input_buffer: RTL and testbench

Per-port input stage of the mesh router. It accepts flits from the link or local core over a req/ack handshake and buffers them in a small FIFO. For the head flit it computes the routing header fields: destination coordinates, the sign of the X/Y deltas, and whether the flit has arrived. These are presented, with the data, to the downstream route logic stage over a second req/ack handshake.

---
 rtl/router_input_buffer.sv | 113 +++++++++++
 tb/tb_router_input_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_buffer.sv
// Per-port router input stage: a small req/ack FIFO of flits whose head entry is
// presented downstream together with routing flags derived from its destination.
module router_input_buffer #(
    parameter int X_COORD   = 0,
    parameter int Y_COORD   = 0,
    parameter int MESH_SIDE = 4,
    parameter int DATA_W    = 512,
    parameter int DEPTH     = 4,
    localparam int CW   = (MESH_SIDE > 1) ? $clog2(MESH_SIDE) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_dest_x,
    input  logic [CW-1:0]     in_dest_y,
    output logic              out_req,
    input  logic              out_ack,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_dest_x,
    output logic [CW-1:0]     out_dest_y,
    output logic              out_s_delta_x,
    output logic              out_s_delta_y,
    output logic              out_at_dest,
    output logic [CNTW-1:0]   count
);

    localparam logic [CW-1:0]   LOC_X     = CW'(X_COORD);
    localparam logic [CW-1:0]   LOC_Y     = CW'(Y_COORD);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [CW-1:0]     r_mem_x    [DEPTH];
    logic [CW-1:0]     r_mem_y    [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]   r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head_data;
    logic [CW-1:0]     w_head_x;
    logic [CW-1:0]     w_head_y;

    assign w_empty = (r_count == {CNTW{1'b0}});
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = in_req && !w_full;
    assign w_pop   = !w_empty && out_ack;

    assign in_ack  = !w_full;
    assign out_req = !w_empty;
    assign count   = r_count;

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_x[r_wr_ptr]    <= in_dest_x;
            r_mem_y[r_wr_ptr]    <= in_dest_y;
        end
    end

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CNTW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNTW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view and routing flags; everything reads zero while the buffer is empty.
    always_comb begin
        w_head_data   = {DATA_W{1'b0}};
        w_head_x      = {CW{1'b0}};
        w_head_y      = {CW{1'b0}};
        out_s_delta_x = 1'b0;
        out_s_delta_y = 1'b0;
        out_at_dest   = 1'b0;
        if (!w_empty) begin
            w_head_data   = r_mem_data[r_rd_ptr];
            w_head_x      = r_mem_x[r_rd_ptr];
            w_head_y      = r_mem_y[r_rd_ptr];
            out_s_delta_x = (w_head_x < LOC_X);
            out_s_delta_y = (w_head_y < LOC_Y);
            out_at_dest   = (w_head_x == LOC_X) && (w_head_y == LOC_Y);
        end else begin
            w_head_data   = {DATA_W{1'b0}};
        end
    end

    assign out_data   = w_head_data;
    assign out_dest_x = w_head_x;
    assign out_dest_y = w_head_y;

endmodule

// File: tb/tb_router_input_buffer.sv
// Randomized and directed bench for router_input_buffer, checked against a
// queue-based model of the FIFO and the routing-flag rules.
module tb_router_input_buffer;

    localparam int XC    = 1;
    localparam int YC    = 2;
    localparam int SIDE  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CNTW  = 3;
    localparam int VW    = 2 + CNTW + DW + 2 * CW + 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } flit_t;

    logic            clk;
    logic            rst;
    logic            in_req;
    logic            in_ack;
    logic [DW-1:0]   in_data;
    logic [CW-1:0]   in_dest_x;
    logic [CW-1:0]   in_dest_y;
    logic            out_req;
    logic            out_ack;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_dest_x;
    logic [CW-1:0]   out_dest_y;
    logic            out_s_delta_x;
    logic            out_s_delta_y;
    logic            out_at_dest;
    logic [CNTW-1:0] count;
    logic [VW-1:0]   w_obs;

    int errors = 0;
    int checks = 0;
    flit_t q[$];

    router_input_buffer #(
        .X_COORD(XC), .Y_COORD(YC), .MESH_SIDE(SIDE), .DATA_W(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
        .out_s_delta_x(out_s_delta_x), .out_s_delta_y(out_s_delta_y),
        .out_at_dest(out_at_dest), .count(count)
    );

    assign w_obs = {out_req, in_ack, count, out_data, out_dest_x, out_dest_y,
                    out_s_delta_x, out_s_delta_y, out_at_dest};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the model queue: head is q[0], flags from coordinate rules.
    function automatic logic [VW-1:0] exp_vec();
        flit_t h;
        logic sdx, sdy, atd;
        h = '0; sdx = 1'b0; sdy = 1'b0; atd = 1'b0;
        if (q.size() != 0) begin
            h   = q[0];
            sdx = (int'(h.x) < XC);
            sdy = (int'(h.y) < YC);
            atd = (int'(h.x) == XC) && (int'(h.y) == YC);
        end
        return {q.size() != 0, q.size() != DEPTH, CNTW'(q.size()), h.d, h.x, h.y, sdx, sdy, atd};
    endfunction

    // One clock: decide model events from pre-edge state, then advance the model.
    task automatic tick();
        bit r, acc, pp;
        flit_t f;
        r   = rst;
        acc = in_req && (q.size() != DEPTH);
        pp  = (q.size() != 0) && out_ack;
        f   = '{in_data, in_dest_x, in_dest_y};
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (pp) q.delete(0);
            if (acc) q.push_back(f);
        end
    endtask

    task automatic set_in(input logic req, input logic [DW-1:0] d,
                          input logic [CW-1:0] x, input logic [CW-1:0] y);
        in_req = req; in_data = d; in_dest_x = x; in_dest_y = y;
    endtask

    task automatic drain();
        in_req = 1'b0; out_ack = 1'b1;
        repeat (DEPTH + 1) tick();
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (out_req !== 1'b0 || in_ack !== 1'b1 || count !== 3'd0 ||
            out_s_delta_x !== 1'b0 || out_s_delta_y !== 1'b0 || out_at_dest !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req=%b ack=%b cnt=%0d flags=%b%b%b want 0 1 0 000",
                     out_req, in_ack, count, out_s_delta_x, out_s_delta_y, out_at_dest);
        end
        checks++;
        if (w_obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_vec: got %h want %h", w_obs, exp_vec());
        end
    endtask

    task automatic test_single_flit();
        set_in(1'b1, 32'h0000_1111, 2'd0, 2'd3);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        checks++;
        if (out_req !== 1'b1 || out_s_delta_x !== 1'b1 || out_s_delta_y !== 1'b0 ||
            out_at_dest !== 1'b0 || out_data !== 32'h0000_1111) begin
            errors++;
            $display("FAIL single_west: got req=%b flags=%b%b%b data=%h want 1 100 00001111",
                     out_req, out_s_delta_x, out_s_delta_y, out_at_dest, out_data);
        end
        drain();
        set_in(1'b1, 32'h0000_2222, 2'd1, 2'd2);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        checks++;
        if (out_req !== 1'b1 || out_s_delta_x !== 1'b0 || out_s_delta_y !== 1'b0 ||
            out_at_dest !== 1'b1) begin
            errors++;
            $display("FAIL single_at_dest: got req=%b flags=%b%b%b want 1 001",
                     out_req, out_s_delta_x, out_s_delta_y, out_at_dest);
        end
        drain();
    endtask

    task automatic test_fill_drain();
        out_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 32'hA + i, 2'd3, 2'd3);
            tick();
        end
        checks++;
        if (count !== 3'd4 || in_ack !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d ack=%b want 4 0", count, in_ack);
        end
        set_in(1'b1, 32'hE, 2'd3, 2'd3);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        checks++;
        if (count !== 3'd4 || out_data !== 32'hA) begin
            errors++;
            $display("FAIL fill_reject: got cnt=%0d head=%h want 4 0000000a", count, out_data);
        end
        out_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_data !== 32'hA + i) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, out_data, 32'hA + i);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (in_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_after_pop: got %b want 1", in_ack);
                end
            end
        end
        out_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || out_req !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got cnt=%0d req=%b want 0 0", count, out_req);
        end
    endtask

    task automatic test_push_pop_count1();
        set_in(1'b1, 32'd100, 2'd0, 2'd0);
        tick();
        out_ack = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b1, 32'd100 + i, CW'(i), CW'(i + 1));
            tick();
            checks++;
            if (count !== 3'd1 || out_data !== 32'd100 + i || w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL pushpop[%0d]: got cnt=%0d data=%0d want 1 %0d",
                         i, count, out_data, 100 + i);
            end
        end
        drain();
    endtask

    task automatic test_stall();
        out_ack = 1'b0;
        set_in(1'b1, 32'hCAFE_0001, 2'd2, 2'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h5000 + i, 2'd0, 2'd0);
            tick();
            checks++;
            if (out_data !== 32'hCAFE_0001 || out_dest_x !== 2'd2 || out_dest_y !== 2'd1 ||
                out_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got data=%h x=%0d y=%0d want cafe0001 2 1",
                         i, out_data, out_dest_x, out_dest_y);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h7700 + i, 2'd3, 2'd0);
            tick();
        end
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre: got cnt=%0d want 3", count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 3'd0 || out_req !== 1'b0 || out_data !== 32'h0 || in_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d req=%b data=%h ack=%b want 0 0 0 1",
                     count, out_req, out_data, in_ack);
        end
        set_in(1'b1, 32'hBEEF_0042, 2'd1, 2'd3);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        checks++;
        if (out_data !== 32'hBEEF_0042 || count !== 3'd1 || out_dest_y !== 2'd3) begin
            errors++;
            $display("FAIL mid_new_head: got data=%h cnt=%0d want beef0042 1", out_data, count);
        end
        drain();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom, CW'($urandom), CW'($urandom));
            out_ack = 1'($urandom_range(0, 2) == 0);
            rst = 1'($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random[%0d]: got %h want %h", i, w_obs, exp_vec());
            end
        end
        drain();
        checks++;
        if (w_obs !== exp_vec() || count !== 3'd0) begin
            errors++;
            $display("FAIL random_drain: got %h want %h", w_obs, exp_vec());
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ack = 1'b0;
        set_in(1'b0, 32'h0, 2'd0, 2'd0);
        test_reset();
        test_single_flit();
        test_fill_drain();
        test_push_pop_count1();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
